// File: rtl/fifo_spi_tx.sv
// Pops words from a read-first FIFO and shifts each out as one SPI mode-0 frame, MSB first.
// sck/mosi/cs_n come straight from flops driven by next-state values, so the pins never glitch.
module fifo_spi_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_rd_en,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  output logic                  spi_cs_n,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           words_sent
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(CS_GAP) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DW-1:0]         div_cnt, div_nxt;
  logic [GW-1:0]         gap_cnt, gap_nxt;
  logic                  phase, phase_nxt;
  logic                  head_valid;
  logic                  done_nxt;
  logic                  ws_inc;

  assign fifo_rd_en = (state == LOAD);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bit_nxt   = bit_cnt;
    div_nxt   = div_cnt;
    gap_nxt   = gap_cnt;
    phase_nxt = phase;
    done_nxt  = 1'b0;
    ws_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && head_valid && !fifo_empty) state_nxt = LOAD;
      end
      LOAD: begin
        shreg_nxt = fifo_rd_data;
        bit_nxt   = '0;
        div_nxt   = '0;
        phase_nxt = 1'b0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (div_cnt == LAST_DIV) begin
          div_nxt   = '0;
          phase_nxt = ~phase;
          // falling sck edge: advance to the next bit while sck goes low
          if (phase) begin
            shreg_nxt = {shreg[DATA_WIDTH-2:0], 1'b0};
            bit_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = GAP;
              gap_nxt   = '0;
              ws_inc    = 1'b1;
            end
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == LAST_GAP) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      phase      <= 1'b0;
      head_valid <= 1'b0;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      frame_done <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_nxt;
      div_cnt    <= div_nxt;
      gap_cnt    <= gap_nxt;
      phase      <= phase_nxt;
      // the BRAM head lags the count by one cycle; a word being popped right now does not count
      head_valid <= (fifo_count > {{ADDR_WIDTH{1'b0}}, fifo_rd_en});
      spi_cs_n   <= (state_nxt != SHIFT);
      spi_sck    <= (state_nxt == SHIFT) && phase_nxt;
      spi_mosi   <= (state_nxt == SHIFT) && shreg_nxt[DATA_WIDTH-1];
      frame_done <= done_nxt;
      words_sent <= words_sent + 16'(ws_inc);
    end
  end

endmodule

// File: tb/tb_fifo_spi_tx.sv
// Bench for fifo_spi_tx: read-first FIFO model upstream, SPI slave monitor downstream,
// expected words queued on write and compared as frames complete.
module tb_fifo_spi_tx;
  localparam int DW        = 32;
  localparam int AW        = 4;
  localparam int CLK_DIV   = 2;
  localparam int CS_GAP    = 2;
  localparam int FRAME_CYC = 2 * CLK_DIV * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          fifo_rd_en, spi_sck, spi_mosi, spi_cs_n, busy, frame_done;
  logic [15:0]   words_sent;

  fifo_spi_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .fifo_rd_en(fifo_rd_en), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .busy(busy), .frame_done(frame_done), .words_sent(words_sent)
  );

  // read-first BRAM FIFO with one cycle of read latency; memory starts filled with junk
  logic [DW-1:0] mem [16];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          pop;
  assign pop          = fifo_rd_en && (cnt != 0);
  assign fifo_count   = cnt;
  assign fifo_empty   = (cnt == 0);

  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      fifo_rd_data <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hBAD0_0000 + 32'(i);
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 1'b1;
      end
      rp <= rp + AW'(pop);
      fifo_rd_data <= mem[rp + AW'(pop)];
      cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  int vec_n = 0;
  int err_n = 0;
  logic [DW-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SPI slave monitor, sampling half a cycle away from the active edge
  int rx_bits = 0, cs_low = 0, gap_cnt = 0, last_gap = 0, rd_cnt = 0;
  logic [DW-1:0] rx_word = '0;
  logic prev_sck = 1'b0, prev_cs = 1'b1, abort_ok = 1'b0;
  logic [DW-1:0] exp_w;

  initial forever begin
    @(negedge clk);
    if (fifo_rd_en) begin
      rd_cnt++;
      check("pop_nonempty", 32'(fifo_empty), 0);
    end
    if (!spi_cs_n && spi_sck && !prev_sck) begin
      rx_word = {rx_word[DW-2:0], spi_mosi};
      rx_bits++;
    end
    if (spi_cs_n && !prev_cs) begin
      if (rx_bits == DW) begin
        check("cs_low_cycles", cs_low, FRAME_CYC);
        check("frame_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check("frame_data", rx_word, exp_w);
        end
      end else if (!abort_ok) begin
        check("frame_bits", rx_bits, DW);
      end
      rx_bits = 0;
      cs_low  = 0;
      gap_cnt = 0;
    end
    if (!spi_cs_n && prev_cs) last_gap = gap_cnt;
    if (!spi_cs_n) cs_low++;
    else gap_cnt++;
    prev_sck = spi_sck;
    prev_cs  = spi_cs_n;
  end

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    sb.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int n, input string name);
    int seen = 0;
    int budget = n * (FRAME_CYC + 50) + 100;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (frame_done) seen++;
      budget--;
    end
    check(name, seen, n);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [15:0]   exp_ws;
  } vec_t;
  vec_t vt[4];

  int rd0, lat, budget;
  logic [15:0] ws_exp;

  initial begin
    vt[0] = '{32'hA5A5_0F0F, 16'd1};
    vt[1] = '{32'hFFFF_FFFF, 16'd2};
    vt[2] = '{32'h0000_0000, 16'd3};
    vt[3] = '{32'h8000_0001, 16'd4};

    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 1);
    check("rst_sck", 32'(spi_sck), 0);
    check("rst_mosi", 32'(spi_mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_words_sent", 32'(words_sent), 0);
    resetn = 1'b1;
    fifo_rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    // single-word frames, one per vector
    for (int i = 0; i < 4; i++) begin
      rd0 = rd_cnt;
      push(vt[i].data);
      wait_done(1, "vec_frame_done");
      check("vec_words_sent", 32'(words_sent), 32'(vt[i].exp_ws));
      check("vec_rd_pulses", rd_cnt - rd0, 1);
      check("vec_busy_idle", 32'(busy), 0);
      check("vec_fifo_empty", 32'(cnt), 0);
    end
    ws_exp = 16'd4;

    // three queued words go out back to back
    enable = 1'b0;
    rd0 = rd_cnt;
    push(32'h1);
    push(32'h2);
    push(32'h3);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_done(3, "b2b_frames");
    ws_exp += 16'd3;
    check("b2b_gap", last_gap, CS_GAP + 2);
    check("b2b_words_sent", 32'(words_sent), 32'(ws_exp));
    check("b2b_rd_pulses", rd_cnt - rd0, 3);
    check("b2b_fifo_empty", 32'(cnt), 0);

    // a fresh write into an empty FIFO must not be loaded from the stale head
    repeat (4) @(negedge clk);
    wr_en = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    sb.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    wr_en = 1'b0;
    lat = 1;
    while (!fifo_rd_en && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("fresh_load_latency_ok", 32'(lat >= 2 && lat < 20), 1);
    wait_done(1, "fresh_frame_done");
    ws_exp += 16'd1;

    // upstream write lands during LOAD with a single word queued
    enable = 1'b0;
    push(32'h600D_F00D);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    budget = 20;
    while (!fifo_rd_en && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("load_seen", 32'(fifo_rd_en), 1);
    wr_en = 1'b1;
    wr_data = 32'h55;
    sb.push_back(32'h55);
    @(negedge clk);
    wr_en = 1'b0;
    check("load_write_count", 32'(cnt), 1);
    wait_done(2, "load_write_frames");
    ws_exp += 16'd2;
    check("load_write_words_sent", 32'(words_sent), 32'(ws_exp));
    check("load_write_fifo_empty", 32'(cnt), 0);

    // enable dropped mid-frame: frame finishes, nothing else is popped
    enable = 1'b0;
    push(32'hCAFE_0001);
    push(32'hCAFE_0002);
    push(32'hCAFE_0003);
    @(negedge clk);
    enable = 1'b1;
    budget = 2 * FRAME_CYC;
    while (rx_bits < 10 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    enable = 1'b0;
    rd0 = rd_cnt;
    wait_done(1, "en_drop_frame_done");
    ws_exp += 16'd1;
    check("en_drop_busy", 32'(busy), 0);
    repeat (40) @(negedge clk);
    check("en_drop_no_pop", rd_cnt - rd0, 0);
    check("en_drop_count", 32'(cnt), 2);
    check("en_drop_idle", 32'(busy), 0);
    enable = 1'b1;
    wait_done(2, "en_drop_drain");
    ws_exp += 16'd2;
    check("en_drop_words_sent", 32'(words_sent), 32'(ws_exp));

    // reset pulse mid-SHIFT aborts the frame
    push(32'h0BAD_CAFE);
    budget = 2 * FRAME_CYC;
    while (rx_bits < 5 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    abort_ok = 1'b1;
    resetn = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 32'(spi_cs_n), 1);
    check("abort_sck", 32'(spi_sck), 0);
    check("abort_mosi", 32'(spi_mosi), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_words_sent", 32'(words_sent), 0);
    resetn = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    abort_ok = 1'b0;
    push(32'h1234_5678);
    wait_done(1, "post_abort_frame");
    check("post_abort_words_sent", 32'(words_sent), 1);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", err_n);
    $fatal(1);
  end

endmodule
